// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: snoops a multiplexed active-low 7-segment bus (SEG + AN)
// and reconstructs the BCD value shown on every digit.
// A scan slot is accepted once its pattern has been stable long enough.
// FRAME_VALID pulses when every digit has been captured since the last pulse.
// Optional feature macro: DP_CAPTURE_EN. When it is defined, the decimal point
// is captured onto DP_OUT and also takes part in the stability check.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [7:0]              SEG,
    input  logic [NUM_DIGITS-1:0]   AN,
    output logic [4*NUM_DIGITS-1:0] BCD_OUT,
    output logic [NUM_DIGITS-1:0]   DIGIT_INVALID,
    output logic                    FRAME_VALID,
    output logic                    GLITCH,
`ifdef DP_CAPTURE_EN
    output logic [NUM_DIGITS-1:0]   DP_OUT,
`endif
    output logic                    STALE
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IDX_W = $clog2(NUM_DIGITS);
`ifdef DP_CAPTURE_EN
    localparam logic [7:0] SEG_CMP_MASK = 8'hFF;
`else
    // dp is left out of the comparison so a toggling dp never restarts qualification
    localparam logic [7:0] SEG_CMP_MASK = 8'hFE;
`endif

    typedef enum logic [1:0] {IDLE, QUALIFY, HOLD, REJECT} state_t;

    state_t                  state, next_state;
    logic [7:0]              seg_meta, s_seg;
    logic [NUM_DIGITS-1:0]   an_meta, s_an, an_prev;
    logic [CNT_W-1:0]        stab_cnt;
    logic [TO_W-1:0]         to_cnt;
    logic [NUM_DIGITS-1:0]   mask;
    logic                    moving, an_changed, an_none, an_one, qualify_done;
    logic                    capture, glitch_set;
    logic [IDX_W-1:0]        slot_idx;
    logic [3:0]              dec_digit;
    logic                    dec_invalid;

    // Two-flop synchronizers for the segment and anode lines, plus the previous anode value
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: synchronizers reset to the idle bus value (everything off), not to zero,
        // so a freshly reset block does not see "all anodes active" and flag a glitch.
        if (!RST_N) begin
            seg_meta <= '1;
            s_seg    <= '1;
            an_meta  <= '1;
            s_an     <= '1;
            an_prev  <= '1;
        end else begin
            // NOTE: every sequential assignment is non-blocking so each flop samples
            // the value from before the edge and the chain shifts by exactly one stage.
            seg_meta <= SEG;
            s_seg    <= seg_meta;
            an_meta  <= AN;
            s_an     <= an_meta;
            an_prev  <= s_an;
        end
    end

    // "moving" looks one stage ahead: the value sSEG/sAN will take next differs from now
    assign moving       = (((seg_meta ^ s_seg) & SEG_CMP_MASK) != 8'h00) || (an_meta != s_an);
    assign an_changed   = (s_an != an_prev);
    assign an_none      = &s_an;
    assign an_one       = $onehot(~s_an);
    assign qualify_done = (stab_cnt == CNT_W'(STABLE_CYCLES - 1)) && !moving;

    // Stability counter: counts consecutive identical synchronized samples, saturating
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stab_cnt <= '0;
        end else if (moving) begin
            stab_cnt <= '0;
        end else if (stab_cnt != CNT_W'(STABLE_CYCLES)) begin
            stab_cnt <= stab_cnt + CNT_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= next_state;
    end

    // FSM next state: re-classify the anodes whenever they change, else hold or finish qualifying
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
        next_state = state;
        if (state == IDLE || an_changed) begin
            if (an_none)     next_state = IDLE;
            else if (an_one) next_state = QUALIFY;
            else             next_state = REJECT;
        end else if (state == QUALIFY && qualify_done) begin
            next_state = HOLD;
        end
    end

    // FSM outputs: capture strobe and glitch pulse request on entry to REJECT
    always_comb begin
        capture    = (state == QUALIFY) && !an_changed && qualify_done;
        glitch_set = (next_state == REJECT) && (state != REJECT || an_changed);
    end

    // Index of the single active anode in the current slot
    always_comb begin
        slot_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!s_an[i]) slot_idx = IDX_W'(i);
        end
    end

    // Segment pattern (a..g, active-low, dp ignored) to BCD digit
    always_comb begin
        dec_invalid = 1'b0;
        case (s_seg[7:1])
            7'b0000001: dec_digit = 4'd0;
            7'b1001111: dec_digit = 4'd1;
            7'b0010010: dec_digit = 4'd2;
            7'b0000110: dec_digit = 4'd3;
            7'b1001100: dec_digit = 4'd4;
            7'b0100100: dec_digit = 4'd5;
            7'b0100000: dec_digit = 4'd6;
            7'b0001111: dec_digit = 4'd7;
            7'b0000000: dec_digit = 4'd8;
            7'b0000100: dec_digit = 4'd9;
            default: begin
                dec_digit   = 4'hF;
                dec_invalid = 1'b1;
            end
        endcase
    end

    // Capture registers, captured mask and frame completion pulse
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BCD_OUT       <= '1;
            DIGIT_INVALID <= '1;
            mask          <= '0;
            FRAME_VALID   <= 1'b0;
`ifdef DP_CAPTURE_EN
            DP_OUT        <= '0;
`endif
        end else begin
            FRAME_VALID <= 1'b0;
            if (capture) begin
                BCD_OUT[{slot_idx, 2'b00} +: 4] <= dec_digit;
                DIGIT_INVALID[slot_idx]         <= dec_invalid;
`ifdef DP_CAPTURE_EN
                DP_OUT[slot_idx]                <= ~s_seg[0];
`endif
                if ((mask | ~s_an) == '1) begin
                    mask        <= '0;
                    FRAME_VALID <= 1'b1;
                end else begin
                    mask <= mask | ~s_an;
                end
            end
        end
    end

    // Registered one-cycle glitch pulse
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) GLITCH <= 1'b0;
        else        GLITCH <= glitch_set;
    end

    // Stale timeout: counts cycles since the last capture, saturating
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            to_cnt <= '0;
        end else if (capture) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign STALE = (to_cnt == TO_W'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder (honours DP_CAPTURE_EN when defined).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
`timescale 1ns/1ps
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 8;
    localparam int TO = 64;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [7:0]      SEG;
    logic [ND-1:0]   AN;
    logic [4*ND-1:0] BCD_OUT;
    logic [ND-1:0]   DIGIT_INVALID;
    logic            FRAME_VALID, GLITCH, STALE;
`ifdef DP_CAPTURE_EN
    logic [ND-1:0]   DP_OUT;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int fv_cnt = 0;
    int gl_cnt = 0;
    logic [6:0] enc_tab [10];

    seg7_scan_decoder #(
        .NUM_DIGITS(ND), .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .SEG(SEG), .AN(AN),
        .BCD_OUT(BCD_OUT), .DIGIT_INVALID(DIGIT_INVALID),
        .FRAME_VALID(FRAME_VALID), .GLITCH(GLITCH),
`ifdef DP_CAPTURE_EN
        .DP_OUT(DP_OUT),
`endif
        .STALE(STALE)
    );

    always #5 CLK = ~CLK;

    // Pulse counters sampled on the falling edge
    always @(negedge CLK) begin
        if (FRAME_VALID === 1'b1) fv_cnt++;
        if (GLITCH === 1'b1) gl_cnt++;
    end

    // Reference decode: search the encoder table; anything not found is {invalid, F}
    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        logic [4:0] r;
        r = 5'h1F;
        for (int d = 0; d < 10; d++) if (enc_tab[d] == p) r = {1'b0, 4'(d)};
        return r;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic slot(input logic [7:0] s, input logic [ND-1:0] a, input int n);
        SEG = s;
        AN  = a;
        cyc(n);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        SEG   = 8'hFF;
        AN    = '1;
        cyc(3);
        RST_N = 1'b1;
        cyc(2);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (BCD_OUT !== 16'hFFFF) begin n_bad++; $display("FAIL reset_bcd: got %h want ffff", BCD_OUT); end
        n_cmp++; if (DIGIT_INVALID !== 4'b1111) begin n_bad++; $display("FAIL reset_inv: got %b want 1111", DIGIT_INVALID); end
        n_cmp++; if (FRAME_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_fv: got %b want 0", FRAME_VALID); end
        n_cmp++; if (GLITCH !== 1'b0) begin n_bad++; $display("FAIL reset_glitch: got %b want 0", GLITCH); end
        n_cmp++; if (STALE !== 1'b0) begin n_bad++; $display("FAIL reset_stale: got %b want 0", STALE); end
`ifdef DP_CAPTURE_EN
        n_cmp++; if (DP_OUT !== 4'b0000) begin n_bad++; $display("FAIL reset_dp: got %b want 0000", DP_OUT); end
`endif
    endtask

    task automatic test_scan();
        int f0;
        do_reset();
        f0 = fv_cnt;
        slot(8'b00001101, 4'b1110, 20);
        slot(8'b00000011, 4'b1101, 20);
        slot(8'b00011111, 4'b1011, 20);
        slot(8'b00001001, 4'b0111, 20);
        slot(8'hFF, 4'b1111, 5);
        n_cmp++; if (BCD_OUT !== 16'h9703) begin n_bad++; $display("FAIL scan_bcd: got %h want 9703", BCD_OUT); end
        n_cmp++; if (DIGIT_INVALID !== 4'b0000) begin n_bad++; $display("FAIL scan_inv: got %b want 0000", DIGIT_INVALID); end
        n_cmp++; if (fv_cnt - f0 !== 1) begin n_bad++; $display("FAIL scan_frames: got %0d want 1", fv_cnt - f0); end
    endtask

    task automatic test_latency();
        do_reset();
        SEG = 8'b01001001;
        AN  = 4'b1110;
        for (int k = 1; k <= SC + 3; k++) begin
            cyc(1);
            if (k == SC + 1) begin
                SEG = 8'hFF;
                AN  = 4'b1111;
                n_cmp++; if (BCD_OUT[3:0] !== 4'hF) begin n_bad++; $display("FAIL latency_early: edge %0d got %h want f", k, BCD_OUT[3:0]); end
            end
            if (k == SC + 2) begin
                n_cmp++; if (BCD_OUT[3:0] !== 4'h5) begin n_bad++; $display("FAIL latency_edge: edge %0d got %h want 5", k, BCD_OUT[3:0]); end
            end
        end
        do_reset();
        slot(8'b01001001, 4'b1110, SC - 1);
        slot(8'hFF, 4'b1111, 20);
        n_cmp++; if (BCD_OUT[3:0] !== 4'hF) begin n_bad++; $display("FAIL short_hold_bcd: got %h want f", BCD_OUT[3:0]); end
        n_cmp++; if (DIGIT_INVALID[0] !== 1'b1) begin n_bad++; $display("FAIL short_hold_inv: got %b want 1", DIGIT_INVALID[0]); end
    endtask

    task automatic test_invalid();
        int f0;
        do_reset();
        f0 = fv_cnt;
        slot({enc_tab[4], 1'b1}, 4'b1110, 20);
        slot(8'b11101111, 4'b1101, 20);
        slot({enc_tab[2], 1'b1}, 4'b1011, 20);
        slot({enc_tab[8], 1'b1}, 4'b0111, 20);
        slot(8'hFF, 4'b1111, 5);
        n_cmp++; if (BCD_OUT !== 16'h82F4) begin n_bad++; $display("FAIL invalid_bcd: got %h want 82f4", BCD_OUT); end
        n_cmp++; if (DIGIT_INVALID !== 4'b0010) begin n_bad++; $display("FAIL invalid_flags: got %b want 0010", DIGIT_INVALID); end
        n_cmp++; if (fv_cnt - f0 !== 1) begin n_bad++; $display("FAIL invalid_frames: got %0d want 1", fv_cnt - f0); end
    endtask

    task automatic test_glitch();
        int f0, g0;
        logic [4*ND-1:0] snap;
        do_reset();
        f0 = fv_cnt;
        g0 = gl_cnt;
        slot({enc_tab[1], 1'b1}, 4'b1110, 20);
        slot({enc_tab[2], 1'b1}, 4'b1101, 20);
        slot(8'hFF, 4'b1111, 5);
        snap = BCD_OUT;
        slot({enc_tab[6], 1'b1}, 4'b1100, 20);
        slot(8'hFF, 4'b1111, 5);
        n_cmp++; if (gl_cnt - g0 !== 1) begin n_bad++; $display("FAIL glitch_pulses: got %0d want 1", gl_cnt - g0); end
        n_cmp++; if (BCD_OUT !== snap) begin n_bad++; $display("FAIL glitch_nocapture: got %h want %h", BCD_OUT, snap); end
        n_cmp++; if (fv_cnt - f0 !== 0) begin n_bad++; $display("FAIL glitch_noframe: got %0d want 0", fv_cnt - f0); end
        slot({enc_tab[3], 1'b1}, 4'b1011, 20);
        slot({enc_tab[4], 1'b1}, 4'b0111, 20);
        slot(8'hFF, 4'b1111, 5);
        n_cmp++; if (fv_cnt - f0 !== 1) begin n_bad++; $display("FAIL glitch_frame: got %0d want 1", fv_cnt - f0); end
        n_cmp++; if (BCD_OUT !== 16'h4321) begin n_bad++; $display("FAIL glitch_bcd: got %h want 4321", BCD_OUT); end
    endtask

    task automatic test_stale();
        do_reset();
        cyc(TO + 10);
        n_cmp++; if (STALE !== 1'b1) begin n_bad++; $display("FAIL stale_idle: got %b want 1", STALE); end
        for (int pass = 0; pass < 2; pass++) begin
            SEG = {enc_tab[7 - pass], 1'b1};
            AN  = 4'b1110;
            for (int k = 1; k <= SC + TO + 4; k++) begin
                cyc(1);
                if (k == SC + 3) begin
                    SEG = 8'hFF;
                    AN  = 4'b1111;
                end
                if (k == SC + 1) begin
                    n_cmp++; if (STALE !== 1'b1) begin n_bad++; $display("FAIL stale_before_cap: pass %0d got %b want 1", pass, STALE); end
                end
                if (k == SC + 2) begin
                    n_cmp++; if (STALE !== 1'b0) begin n_bad++; $display("FAIL stale_after_cap: pass %0d got %b want 0", pass, STALE); end
                end
                if (k == SC + 1 + TO) begin
                    n_cmp++; if (STALE !== 1'b0) begin n_bad++; $display("FAIL stale_early: pass %0d got %b want 0", pass, STALE); end
                end
                if (k == SC + 2 + TO) begin
                    n_cmp++; if (STALE !== 1'b1) begin n_bad++; $display("FAIL stale_rise: pass %0d got %b want 1", pass, STALE); end
                end
            end
            n_cmp++; if (BCD_OUT[3:0] !== 4'(7 - pass)) begin n_bad++; $display("FAIL stale_bcd: got %h want %0d", BCD_OUT[3:0], 7 - pass); end
        end
    endtask

    task automatic test_reset_mid();
        int f0;
        do_reset();
        slot({enc_tab[1], 1'b1}, 4'b1110, 20);
        slot({enc_tab[5], 1'b1}, 4'b1101, 20);
        slot({enc_tab[6], 1'b0}, 4'b1011, 20);
        slot(8'hFF, 4'b1111, 3);
        n_cmp++; if (BCD_OUT[11:0] !== 12'h651) begin n_bad++; $display("FAIL mid_pre_bcd: got %h want 651", BCD_OUT[11:0]); end
`ifdef DP_CAPTURE_EN
        n_cmp++; if (DP_OUT !== 4'b0100) begin n_bad++; $display("FAIL mid_dp: got %b want 0100", DP_OUT); end
`endif
        RST_N = 1'b0;
        #1;
        n_cmp++; if (BCD_OUT !== 16'hFFFF) begin n_bad++; $display("FAIL mid_rst_bcd: got %h want ffff", BCD_OUT); end
        n_cmp++; if (DIGIT_INVALID !== 4'b1111) begin n_bad++; $display("FAIL mid_rst_inv: got %b want 1111", DIGIT_INVALID); end
        n_cmp++; if (FRAME_VALID !== 1'b0 || GLITCH !== 1'b0 || STALE !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_flags: got fv=%b gl=%b st=%b want 000", FRAME_VALID, GLITCH, STALE); end
`ifdef DP_CAPTURE_EN
        n_cmp++; if (DP_OUT !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_dp: got %b want 0000", DP_OUT); end
`endif
        cyc(2);
        RST_N = 1'b1;
        cyc(2);
        f0 = fv_cnt;
        slot({enc_tab[8], 1'b1}, 4'b0111, 20);
        slot(8'hFF, 4'b1111, 5);
        n_cmp++; if (fv_cnt - f0 !== 0) begin n_bad++; $display("FAIL mid_noframe: got %0d want 0", fv_cnt - f0); end
        n_cmp++; if (BCD_OUT !== 16'h8FFF) begin n_bad++; $display("FAIL mid_post_bcd: got %h want 8fff", BCD_OUT); end
        n_cmp++; if (DIGIT_INVALID !== 4'b0111) begin n_bad++; $display("FAIL mid_post_inv: got %b want 0111", DIGIT_INVALID); end
    endtask

    task automatic test_random();
        localparam int NF = 6;
        int f0, start, idx, hold, gap;
        logic [4*ND-1:0] exp_bcd;
        logic [ND-1:0]   exp_inv, exp_dp, sel;
        logic [6:0]      pat;
        logic [4:0]      r;
        logic            dp;
        do_reset();
        f0 = fv_cnt;
        for (int f = 0; f < NF; f++) begin
            start   = int'($urandom_range(0, ND - 1));
            exp_bcd = BCD_OUT;
            exp_inv = DIGIT_INVALID;
            exp_dp  = '0;
            for (int j = 0; j < ND; j++) begin
                idx = (start + j) % ND;
                if ($urandom_range(0, 4) == 0) pat = 7'($urandom);
                else                           pat = enc_tab[$urandom_range(0, 9)];
                dp   = 1'($urandom);
                r    = ref_decode(pat);
                exp_bcd[4*idx +: 4] = r[3:0];
                exp_inv[idx]        = r[4];
                exp_dp[idx]         = ~dp;
                sel      = '0;
                sel[idx] = 1'b1;
                AN       = ~sel;
                hold     = int'($urandom_range(12, 24));
                for (int c = 0; c < hold; c++) begin
`ifdef DP_CAPTURE_EN
                    SEG = {pat, dp};
`else
                    SEG = {pat, 1'($urandom)};
`endif
                    cyc(1);
                end
                gap = int'($urandom_range(0, 3));
                if (gap > 0) slot(8'hFF, 4'b1111, gap);
            end
            slot(8'hFF, 4'b1111, 4);
            n_cmp++; if (BCD_OUT !== exp_bcd) begin n_bad++; $display("FAIL rand_bcd: frame %0d got %h want %h", f, BCD_OUT, exp_bcd); end
            n_cmp++; if (DIGIT_INVALID !== exp_inv) begin n_bad++; $display("FAIL rand_inv: frame %0d got %b want %b", f, DIGIT_INVALID, exp_inv); end
`ifdef DP_CAPTURE_EN
            n_cmp++; if (DP_OUT !== exp_dp) begin n_bad++; $display("FAIL rand_dp: frame %0d got %b want %b", f, DP_OUT, exp_dp); end
`endif
        end
        n_cmp++; if (fv_cnt - f0 !== NF) begin n_bad++; $display("FAIL rand_frames: got %0d want %0d", fv_cnt - f0, NF); end
    endtask

    initial begin
        enc_tab[0] = 7'b0000001; enc_tab[1] = 7'b1001111; enc_tab[2] = 7'b0010010;
        enc_tab[3] = 7'b0000110; enc_tab[4] = 7'b1001100; enc_tab[5] = 7'b0100100;
        enc_tab[6] = 7'b0100000; enc_tab[7] = 7'b0001111; enc_tab[8] = 7'b0000000;
        enc_tab[9] = 7'b0000100;
        RST_N = 1'b0;
        SEG   = 8'hFF;
        AN    = '1;
        test_reset();
        test_scan();
        test_latency();
        test_invalid();
        test_glitch();
        test_stale();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
